// File: rtl/frame_swap_controller_if.sv
// Column-write and commit handshake between a frame producer and the
// double-buffered frame store.
interface frame_swap_controller_if #(
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 20,
  parameter int COL_BITS     = $clog2(FRAME_WIDTH)
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [COL_BITS-1:0]     wr_col;
  logic [FRAME_HEIGHT-1:0] wr_R;
  logic [FRAME_HEIGHT-1:0] wr_G;
  logic [FRAME_HEIGHT-1:0] wr_B;
  logic                    clear_req;
  logic                    commit_req;
  logic                    commit_done;
  logic                    wr_error;

  // Producer side: offers column writes, clears and commits.
  modport master (
    output wr_valid, wr_col, wr_R, wr_G, wr_B, clear_req, commit_req,
    input  wr_ready, commit_done, wr_error
  );

  // Frame store side.
  modport slave (
    input  wr_valid, wr_col, wr_R, wr_G, wr_B, clear_req, commit_req,
    output wr_ready, commit_done, wr_error
  );
endinterface

// File: rtl/frame_swap_controller.sv
// Double-buffered column frame store. The producer fills the back buffer
// column by column; a commit copies it to the front buffer on the next
// vertical-blanking entry so the renderer never sees a half-written frame.
module frame_swap_controller #(
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 20,
  parameter int PIXEL_Y_BITS = 10,
  parameter int VBLANK_LINE  = 480,
  parameter int COL_BITS     = $clog2(FRAME_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PIXEL_Y_BITS-1:0] pixel_y_target_next,
  frame_swap_controller_if.slave  bus,
  output logic [FRAME_HEIGHT-1:0] frame_R [FRAME_WIDTH],
  output logic [FRAME_HEIGHT-1:0] frame_G [FRAME_WIDTH],
  output logic [FRAME_HEIGHT-1:0] frame_B [FRAME_WIDTH],
  output logic [15:0]             frame_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } state_t;

  typedef logic [FRAME_HEIGHT-1:0] column_t;

  state_t  state_q, state_d;
  column_t back_r_q  [FRAME_WIDTH];
  column_t back_g_q  [FRAME_WIDTH];
  column_t back_b_q  [FRAME_WIDTH];
  column_t back_r_d  [FRAME_WIDTH];
  column_t back_g_d  [FRAME_WIDTH];
  column_t back_b_d  [FRAME_WIDTH];
  column_t front_r_q [FRAME_WIDTH];
  column_t front_g_q [FRAME_WIDTH];
  column_t front_b_q [FRAME_WIDTH];
  column_t front_r_d [FRAME_WIDTH];
  column_t front_g_d [FRAME_WIDTH];
  column_t front_b_d [FRAME_WIDTH];
  logic [15:0] frame_count_q, frame_count_d;
  logic        wr_error_q, wr_error_d;
  logic        commit_done_q, commit_done_d;
  logic        in_vblank_q;

  logic in_vblank;
  logic vblank_rise;
  logic wr_accept;
  logic col_in_range;

  assign in_vblank    = (pixel_y_target_next >= PIXEL_Y_BITS'(VBLANK_LINE));
  assign vblank_rise  = in_vblank && !in_vblank_q;
  assign wr_accept    = bus.wr_valid && (state_q == IDLE);
  assign col_in_range = (int'(bus.wr_col) < FRAME_WIDTH);

  assign bus.wr_ready    = (state_q == IDLE);
  assign bus.commit_done = commit_done_q;
  assign bus.wr_error    = wr_error_q;
  assign frame_count     = frame_count_q;
  assign frame_R         = front_r_q;
  assign frame_G         = front_g_q;
  assign frame_B         = front_b_q;

  // Next-state, buffer update and swap logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d       = state_q;
    back_r_d      = back_r_q;
    back_g_d      = back_g_q;
    back_b_d      = back_b_q;
    front_r_d     = front_r_q;
    front_g_d     = front_g_q;
    front_b_d     = front_b_q;
    frame_count_d = frame_count_q;
    wr_error_d    = wr_error_q;
    commit_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Clear first so a simultaneous write lands on the zeroed buffer.
        if (bus.clear_req) begin
          back_r_d = '{default: '0};
          back_g_d = '{default: '0};
          back_b_d = '{default: '0};
        end
        if (wr_accept) begin
          if (col_in_range) begin
            for (int i = 0; i < FRAME_WIDTH; i++) begin
              if (int'(bus.wr_col) == i) begin
                back_r_d[i] = bus.wr_R;
                back_g_d[i] = bus.wr_G;
                back_b_d[i] = bus.wr_B;
              end
            end
          end else begin
            wr_error_d = 1'b1;
          end
        end
        // A blanking edge seen in this same cycle is deliberately ignored:
        // the swap waits for a rise observed while already PENDING.
        if (bus.commit_req) state_d = PENDING;
      end
      PENDING: begin
        if (vblank_rise) state_d = SWAP;
      end
      SWAP: begin
        front_r_d     = back_r_q;
        front_g_d     = back_g_q;
        front_b_d     = back_b_q;
        frame_count_d = frame_count_q + 16'd1;
        commit_done_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, buffer and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      // NOTE: both buffers are reset because a reset mid-commit must leave
      // the renderer a blank frame rather than stale or partial contents.
      back_r_q      <= '{default: '0};
      back_g_q      <= '{default: '0};
      back_b_q      <= '{default: '0};
      front_r_q     <= '{default: '0};
      front_g_q     <= '{default: '0};
      front_b_q     <= '{default: '0};
      frame_count_q <= '0;
      wr_error_q    <= 1'b0;
      commit_done_q <= 1'b0;
      // Start as "in blanking" so releasing reset during blanking is no edge.
      in_vblank_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, so update order inside this block is irrelevant.
      state_q       <= state_d;
      back_r_q      <= back_r_d;
      back_g_q      <= back_g_d;
      back_b_q      <= back_b_d;
      front_r_q     <= front_r_d;
      front_g_q     <= front_g_d;
      front_b_q     <= front_b_d;
      frame_count_q <= frame_count_d;
      wr_error_q    <= wr_error_d;
      commit_done_q <= commit_done_d;
      in_vblank_q   <= in_vblank;
    end
  end

endmodule

// File: tb/tb_frame_swap_controller.sv
// Directed bench for frame_swap_controller: write/commit/swap timing,
// stalls while pending, out-of-range writes, clear, counter wrap, reset abort.
module tb_frame_swap_controller;
  localparam int W  = 10;
  localparam int H  = 20;
  localparam int YB = 10;
  localparam int CB = $clog2(W);

  logic          clk;
  logic          reset;
  logic [YB-1:0] pixel_y;
  logic [H-1:0]  frame_R [W];
  logic [H-1:0]  frame_G [W];
  logic [H-1:0]  frame_B [W];
  logic [15:0]   frame_count;

  int checks = 0;
  int errors = 0;

  frame_swap_controller_if #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COL_BITS(CB)) bus ();

  frame_swap_controller #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .PIXEL_Y_BITS(YB),
    .VBLANK_LINE (480),
    .COL_BITS    (CB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .pixel_y_target_next(pixel_y),
    .bus                (bus),
    .frame_R            (frame_R),
    .frame_G            (frame_G),
    .frame_B            (frame_B),
    .frame_count        (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Commit from IDLE and walk y 479 -> 480 so the swap completes; returns
  // one cycle after the SWAP edge (commit_done visible).
  task automatic do_commit();
    pixel_y        = 10'd479;
    bus.commit_req = 1'b1;
    step();
    bus.commit_req = 1'b0;
    step();
    pixel_y = 10'd480;
    step();
    step();
  endtask

  initial begin
    reset          = 1'b0;
    pixel_y        = 10'd0;
    bus.wr_valid   = 1'b0;
    bus.wr_col     = '0;
    bus.wr_R       = '0;
    bus.wr_G       = '0;
    bus.wr_B       = '0;
    bus.clear_req  = 1'b0;
    bus.commit_req = 1'b0;

    // Reset state
    #12;
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("rst_commit_done", 64'(bus.commit_done), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_wr_error", 64'(bus.wr_error), 64'd0);
    check("rst_front_r3", 64'(frame_R[3]), 64'd0);
    @(negedge clk);
    reset   = 1'b1;
    pixel_y = 10'd100;
    step();

    // Basic write, commit, swap on 479->480
    bus.wr_valid = 1'b1;
    bus.wr_col   = 4'd3;
    bus.wr_R     = 20'h00001;
    step();
    bus.wr_valid = 1'b0;
    bus.wr_R     = '0;
    check("a_front_before_commit", 64'(frame_R[3]), 64'd0);
    bus.commit_req = 1'b1;
    step();
    bus.commit_req = 1'b0;
    check("a_pending_ready", 64'(bus.wr_ready), 64'd0);
    pixel_y = 10'd479;
    step();
    check("a_no_done_yet", 64'(bus.commit_done), 64'd0);
    pixel_y = 10'd480;
    step();
    check("a_front_at_rise", 64'(frame_R[3]), 64'd0);
    check("a_swap_ready", 64'(bus.wr_ready), 64'd0);
    step();
    check("a_front_r3", 64'(frame_R[3]), 64'h00001);
    check("a_commit_done", 64'(bus.commit_done), 64'd1);
    check("a_frame_count", 64'(frame_count), 64'd1);
    check("a_ready_after", 64'(bus.wr_ready), 64'd1);
    step();
    check("a_done_one_cycle", 64'(bus.commit_done), 64'd0);

    // Commit in the same cycle as the blanking edge waits a frame
    pixel_y = 10'd479;
    step();
    pixel_y        = 10'd480;
    bus.commit_req = 1'b1;
    step();
    bus.commit_req = 1'b0;
    step();
    step();
    check("b_still_pending", 64'(bus.wr_ready), 64'd0);
    check("b_no_done", 64'(bus.commit_done), 64'd0);
    check("b_count_held", 64'(frame_count), 64'd1);
    pixel_y = 10'd479;
    step();
    pixel_y = 10'd480;
    step();
    check("b_in_swap", 64'(bus.wr_ready), 64'd0);
    step();
    check("b_commit_done", 64'(bus.commit_done), 64'd1);
    check("b_frame_count", 64'(frame_count), 64'd2);

    // Writes stall while pending, then land after the swap
    pixel_y        = 10'd479;
    bus.commit_req = 1'b1;
    step();
    bus.commit_req = 1'b0;
    bus.wr_valid   = 1'b1;
    bus.wr_col     = 4'd5;
    bus.wr_B       = 20'hABCDE;
    step();
    check("c_stall_ready", 64'(bus.wr_ready), 64'd0);
    pixel_y = 10'd480;
    step();
    check("c_swap_ready", 64'(bus.wr_ready), 64'd0);
    step();
    check("c_front_excludes", 64'(frame_B[5]), 64'd0);
    check("c_commit_done", 64'(bus.commit_done), 64'd1);
    check("c_ready_idle", 64'(bus.wr_ready), 64'd1);
    step();
    bus.wr_valid = 1'b0;
    bus.wr_B     = '0;
    do_commit();
    check("c_front_b5", 64'(frame_B[5]), 64'hABCDE);
    check("c_back_kept_r3", 64'(frame_R[3]), 64'h00001);
    check("c_frame_count", 64'(frame_count), 64'd4);

    // Out-of-range column write
    bus.wr_valid = 1'b1;
    bus.wr_col   = 4'd12;
    bus.wr_R     = 20'hFFFFF;
    step();
    bus.wr_valid = 1'b0;
    bus.wr_R     = '0;
    check("d_wr_error_set", 64'(bus.wr_error), 64'd1);
    do_commit();
    check("d_wr_error_sticky", 64'(bus.wr_error), 64'd1);
    check("d_front_r3", 64'(frame_R[3]), 64'h00001);
    check("d_front_r4", 64'(frame_R[4]), 64'd0);
    check("d_front_r2", 64'(frame_R[2]), 64'd0);
    check("d_frame_count", 64'(frame_count), 64'd5);

    // Clear plus write in one cycle; clear while pending is ignored
    bus.clear_req = 1'b1;
    bus.wr_valid  = 1'b1;
    bus.wr_col    = 4'd0;
    bus.wr_G      = 20'hFFFFF;
    step();
    bus.clear_req  = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_G       = '0;
    pixel_y        = 10'd479;
    bus.commit_req = 1'b1;
    step();
    bus.commit_req = 1'b0;
    bus.clear_req  = 1'b1;
    step();
    bus.clear_req = 1'b0;
    pixel_y       = 10'd480;
    step();
    step();
    check("e_front_g0", 64'(frame_G[0]), 64'hFFFFF);
    check("e_front_r0", 64'(frame_R[0]), 64'd0);
    check("e_front_b0", 64'(frame_B[0]), 64'd0);
    for (int i = 1; i < W; i++) begin
      check($sformatf("e_col%0d_rgb", i),
            64'({frame_R[i], frame_G[i], frame_B[i]}), 64'd0);
    end
    check("e_frame_count", 64'(frame_count), 64'd6);
    check("e_wr_error", 64'(bus.wr_error), 64'd1);

    // Counter wrap from 16'hFFFF
    force dut.frame_count_q = 16'hFFFF;
    step();
    release dut.frame_count_q;
    do_commit();
    check("f_count_wrap", 64'(frame_count), 64'd0);
    check("f_wrap_done", 64'(bus.commit_done), 64'd1);

    // Reset during PENDING aborts the commit
    pixel_y        = 10'd479;
    bus.commit_req = 1'b1;
    step();
    bus.commit_req = 1'b0;
    check("g_pending", 64'(bus.wr_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("g_rst_ready", 64'(bus.wr_ready), 64'd1);
    check("g_rst_front_g0", 64'(frame_G[0]), 64'd0);
    check("g_rst_error", 64'(bus.wr_error), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    pixel_y = 10'd480;
    step();
    step();
    step();
    check("g_no_done", 64'(bus.commit_done), 64'd0);
    check("g_idle_ready", 64'(bus.wr_ready), 64'd1);
    check("g_front_g0", 64'(frame_G[0]), 64'd0);
    check("g_frame_count", 64'(frame_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
